strip_trig_info_receiver: RTL and testbench
===========================================

STRIP_TRIG_INFO_RECEIVER -- requirements
Module: strip_trig_info_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, sole clock; link inputs are sampled on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port trig_en, input, 1, frame-enable lane; high marks a data beat.
REQ-005 SHALL have ports trig_d1 and trig_d0, input, 1 each, data lanes; d1 carries the more significant bit of each beat.
REQ-006 SHALL have port info_tds, output, 2, TDS id of the head word.
REQ-007 SHALL have port info_band, output, 8, band id of the head word.
REQ-008 SHALL have port info_phi, output, 6, phi id of the head word.
REQ-009 SHALL have port info_bcid, output, 8, BC tag of the head word.
REQ-010 SHALL have ports info_valid (output, 1) and info_ready (input, 1), forming the consumer handshake.
REQ-011 SHALL have ports frame_err_count, crc_err_count and overflow_count, output, 16 each, saturating error counters.

Function
REQ-012 Frame: 16 consecutive beats with trig_en high, 2 bits per beat, MSB-first, forming a 32-bit word; beat 1 carries bits [31:30].
REQ-013 Word layout: [31:28] sync = 4'hA; [27:26] tds; [25:18] band; [17:12] phi; [11:4] bcid; [3:0] checksum = XOR of nibbles [31:28] down to [7:4].
REQ-014 FSM states: IDLE and SHIFT. IDLE -> SHIFT on a sampled trig_en=1, and the beat count becomes 1. SHIFT counts beats 1..16.
REQ-015 On beat 16, the word SHALL be evaluated from the shift register plus the current beat, in the same cycle.
REQ-016 On beat 16, if trig_en is high on the next edge, the FSM SHALL stay in SHIFT and treat that beat as beat 1 of a new frame (back-to-back frames, zero gap). Otherwise it returns to IDLE.
REQ-017 trig_en low in SHIFT before beat 16 (truncation) SHALL discard the partial word, increment frame_err_count, and go to IDLE.
REQ-018 A sync nibble not equal to 4'hA SHALL discard the word and increment frame_err_count; the sync check takes precedence over the checksum check.
REQ-019 A correct sync with a checksum mismatch SHALL discard the word and increment crc_err_count.
REQ-020 A good word SHALL be written to the FIFO on the edge that samples beat 16; info_valid SHALL be high in the following cycle (latency 1 cycle) if the FIFO was empty.
REQ-021 Handshake: a pop occurs when info_valid and info_ready are both high. Outputs SHALL show the head word while info_valid is high and SHALL stay stable until popped.
REQ-022 Good word with FIFO full and no simultaneous pop: the word is dropped and overflow_count increments. Full with a simultaneous pop: the write is accepted.
REQ-023 All counters SHALL saturate at 16'hFFFF and never wrap.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit used to distinguish full from empty.

Reset
REQ-025 Asserting reset SHALL asynchronously force IDLE, beat count 0, FIFO empty, info_valid=0, all info fields 0, and all counters 0.
REQ-026 A frame in progress when reset asserts SHALL be lost with no counter change; reception restarts at the first trig_en=1 after reset deasserts.

Structure
REQ-027 The shared package SHALL hold SYNC_NIBBLE=4'hA, FRAME_BEATS=16, the field bit positions, the FSM state enum, and the checksum function.
REQ-028 The output buffer SHALL be one sub-module, strip_trig_info_fifo (synchronous FIFO, width 24, depth FIFO_DEPTH); all other logic stays in the top module.

Verification
REQ-029 Single frame 32'hA4F157EC, info_ready=1: one cycle after beat 16, info_valid=1 with tds=1, band=8'h3C, phi=6'h15, bcid=8'h7E; all counters 0.
REQ-030 Two frames back-to-back (0xA4F157EC, then the same word with bcid=8'h7F and the checksum recomputed to D): both are delivered in order with no error.
REQ-031 trig_en dropped after beat 9: frame_err_count=1, nothing delivered; a following good frame is delivered normally.
REQ-032 0xA4F157ED (bad checksum) -> crc_err_count=1. 0xB4F157EC (bad sync) -> frame_err_count=1, crc_err_count unchanged.
REQ-033 info_ready=0 with 6 good frames sent, FIFO_DEPTH=4: 4 words are held and overflow_count=2. Then raise info_ready: 4 words pop in order, and info_valid falls after the 4th.
REQ-034 Reset asserted at beat 8: FSM returns to IDLE, counters stay 0, and the next full frame is delivered correctly.

Source files
------------

// File: rtl/strip_trig_info_receiver_pkg.sv
// strip_trig_info_receiver_pkg: shared constants, field positions, FSM states and checksum for the trigger-info link
package strip_trig_info_receiver_pkg;
    localparam logic [3:0] SYNC_NIBBLE = 4'hA;
    localparam int FRAME_BEATS = 16;
    localparam int SYNC_LSB = 28;
    localparam int TDS_LSB = 26;
    localparam int BAND_LSB = 18;
    localparam int PHI_LSB = 12;
    localparam int BCID_LSB = 4;
    localparam int INFO_W = SYNC_LSB - BCID_LSB;
    typedef enum logic {IDLE, SHIFT} state_t;
    function automatic logic [3:0] checksum(input logic [31:0] w);
        checksum = w[31:28] ^ w[27:24] ^ w[23:20] ^ w[19:16] ^ w[15:12] ^ w[11:8] ^ w[7:4];
    endfunction
endpackage

// File: rtl/strip_trig_info_fifo.sv
// strip_trig_info_fifo: synchronous FIFO; clk/reset, wr_en/wr_data push, rd_en pop, rd_data head, full/empty flags
module strip_trig_info_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic push, pop;
    assign empty = wr_ptr == rd_ptr;
    assign full = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
    assign pop = rd_en && !empty;
    // a write into a full FIFO is fine when the head leaves on the same edge
    assign push = wr_en && (!full || pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(push);
            rd_ptr <= rd_ptr + (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/strip_trig_info_receiver.sv
// strip_trig_info_receiver: deserialises 16-beat 2-lane trigger frames, checks sync/checksum, buffers info words
// ports: clk/reset; trig_en, trig_d1, trig_d0 link lanes; info_* head word with info_valid/info_ready handshake;
// frame_err_count, crc_err_count, overflow_count saturating error counters
module strip_trig_info_receiver
    import strip_trig_info_receiver_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trig_en,
    input  logic        trig_d1,
    input  logic        trig_d0,
    output logic [1:0]  info_tds,
    output logic [7:0]  info_band,
    output logic [5:0]  info_phi,
    output logic [7:0]  info_bcid,
    output logic        info_valid,
    input  logic        info_ready,
    output logic [15:0] frame_err_count,
    output logic [15:0] crc_err_count,
    output logic [15:0] overflow_count
);
    state_t state, state_nx;
    logic [4:0] beat, beat_nx;
    logic [29:0] sr, sr_nx;
    logic [31:0] word;
    logic [INFO_W-1:0] head;
    logic last_beat, trunc, sync_ok, crc_ok, good, full, empty, pop, push;
    logic frame_inc, crc_inc, ovf_inc;
    // the beat being sampled completes the word, so it is evaluated without waiting a cycle
    assign word = {sr, trig_d1, trig_d0};
    assign last_beat = state == SHIFT && trig_en && beat == 5'(FRAME_BEATS - 1);
    // beat count at FRAME_BEATS means the previous frame finished cleanly, so dropping trig_en is a normal gap
    assign trunc = state == SHIFT && !trig_en && beat != 5'(FRAME_BEATS);
    assign sync_ok = word[31:SYNC_LSB] == SYNC_NIBBLE;
    assign crc_ok = word[3:0] == checksum(word);
    assign good = last_beat && sync_ok && crc_ok;
    assign frame_inc = trunc || (last_beat && !sync_ok);
    assign crc_inc = last_beat && sync_ok && !crc_ok;
    assign pop = info_valid && info_ready;
    assign push = good && (!full || pop);
    assign ovf_inc = good && full && !pop;
    assign info_valid = !empty;
    assign {info_tds, info_band, info_phi, info_bcid} = info_valid ? head : '0;
    always_comb begin
        state_nx = trig_en ? SHIFT : IDLE;
        beat_nx = !trig_en ? 5'd0 : (state == IDLE || beat == 5'(FRAME_BEATS)) ? 5'd1 : beat + 5'd1;
        sr_nx = trig_en ? {sr[27:0], trig_d1, trig_d0} : sr;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            beat <= '0;
            sr <= '0;
        end else begin
            state <= state_nx;
            beat <= beat_nx;
            sr <= sr_nx;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err_count <= '0;
            crc_err_count <= '0;
            overflow_count <= '0;
        end else begin
            frame_err_count <= frame_err_count + 16'(frame_inc && frame_err_count != 16'hFFFF);
            crc_err_count <= crc_err_count + 16'(crc_inc && crc_err_count != 16'hFFFF);
            overflow_count <= overflow_count + 16'(ovf_inc && overflow_count != 16'hFFFF);
        end
    end
    strip_trig_info_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INFO_W)) u_fifo (
        .clk(clk),
        .reset(reset),
        .wr_en(push),
        .wr_data(word[SYNC_LSB-1:BCID_LSB]),
        .rd_en(pop),
        .rd_data(head),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_strip_trig_info_receiver.sv
// tb_strip_trig_info_receiver: directed frames with a scoreboard queue checked by an independent monitor
module tb_strip_trig_info_receiver;
    logic clk = 0, reset = 0, trig_en = 0, trig_d1 = 0, trig_d0 = 0, info_ready = 0;
    logic [1:0] info_tds;
    logic [7:0] info_band, info_bcid;
    logic [5:0] info_phi;
    logic info_valid;
    logic [15:0] frame_err_count, crc_err_count, overflow_count;
    logic [23:0] exp_q [$];
    int checks = 0, errors = 0;

    strip_trig_info_receiver #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .trig_en(trig_en), .trig_d1(trig_d1), .trig_d0(trig_d0),
        .info_tds(info_tds), .info_band(info_band), .info_phi(info_phi), .info_bcid(info_bcid),
        .info_valid(info_valid), .info_ready(info_ready),
        .frame_err_count(frame_err_count), .crc_err_count(crc_err_count), .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // word A4F15 + bcid + checksum; the fixed nibbles A,4,F,1,5 XOR to 5
    function automatic logic [31:0] mk_word(input logic [7:0] bcid);
        mk_word = {20'hA4F15, bcid, 4'h5 ^ bcid[7:4] ^ bcid[3:0]};
    endfunction

    task automatic send_beats(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            trig_en = 1;
            trig_d1 = w[31 - 2*i];
            trig_d0 = w[30 - 2*i];
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            trig_en = 0;
            trig_d1 = 0;
            trig_d0 = 0;
        end
    endtask

    // a pop happens on the next rising edge whenever valid and ready are both high here
    always @(negedge clk) begin
        if (!reset && info_valid && info_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", {info_tds, info_band, info_phi, info_bcid});
            end else
                check("delivered_word", {8'h0, info_tds, info_band, info_phi, info_bcid}, {8'h0, exp_q.pop_front()});
        end
    end

    initial begin
        reset = 1;
        #12;
        check("reset_valid", info_valid, 0);
        check("reset_fields", {info_tds, info_band, info_phi, info_bcid}, 0);
        check("reset_frame_err", frame_err_count, 0);
        check("reset_crc_err", crc_err_count, 0);
        check("reset_overflow", overflow_count, 0);
        @(posedge clk); #2;
        reset = 0;
        info_ready = 1;
        idle(2);

        exp_q.push_back({2'd1, 8'h3C, 6'h15, 8'h7E});
        send_beats(32'hA4F157EC, 16);
        check("latency_before", info_valid, 0);
        idle(1);
        check("latency_valid", info_valid, 1);
        check("single_bcid", info_bcid, 8'h7E);
        idle(3);
        check("single_counters", {frame_err_count, crc_err_count}, 0);

        exp_q.push_back({2'd1, 8'h3C, 6'h15, 8'h7E});
        exp_q.push_back({2'd1, 8'h3C, 6'h15, 8'h7F});
        send_beats(32'hA4F157EC, 16);
        send_beats(32'hA4F157FD, 16);
        idle(4);
        check("b2b_frame_err", frame_err_count, 0);
        check("b2b_crc_err", crc_err_count, 0);
        check("b2b_overflow", overflow_count, 0);

        send_beats(32'hA4F157EC, 9);
        idle(3);
        check("trunc_frame_err", frame_err_count, 1);
        check("trunc_nothing", info_valid, 0);
        exp_q.push_back({2'd1, 8'h3C, 6'h15, 8'h7E});
        send_beats(32'hA4F157EC, 16);
        idle(3);

        send_beats(32'hA4F157ED, 16);
        idle(3);
        check("crc_err", crc_err_count, 1);
        check("crc_frame_err", frame_err_count, 1);
        send_beats(32'hB4F157EC, 16);
        idle(3);
        check("sync_frame_err", frame_err_count, 2);
        check("sync_crc_err", crc_err_count, 1);
        check("bad_nothing", info_valid, 0);

        info_ready = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back({2'd1, 8'h3C, 6'h15, 8'h70 + 8'(i)});
            send_beats(mk_word(8'h70 + 8'(i)), 16);
        end
        idle(3);
        check("ovf_count", overflow_count, 2);
        check("ovf_valid", info_valid, 1);
        check("ovf_head_stable", info_bcid, 8'h70);
        info_ready = 1;
        idle(6);
        check("ovf_drained", info_valid, 0);
        check("ovf_queue", exp_q.size(), 0);

        send_beats(32'hA4F157EC, 8);
        reset = 1;
        trig_en = 0;
        #1;
        check("rst_async_valid", info_valid, 0);
        check("rst_counters", {frame_err_count, crc_err_count}, 0);
        check("rst_overflow", overflow_count, 0);
        @(posedge clk); #2;
        reset = 0;
        idle(2);
        check("rst_no_err", frame_err_count, 0);
        exp_q.push_back({2'd1, 8'h3C, 6'h15, 8'h7E});
        send_beats(32'hA4F157EC, 16);
        idle(1);
        check("rst_next_valid", info_valid, 1);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_frame_err", frame_err_count, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
